// File: rtl/smg_pkg.sv
// rtl/smg_pkg.sv - shared segment patterns, column codes and scan state encoding
package smg_pkg;

    localparam logic [7:0] _0 = 8'b1100_0000;
    localparam logic [7:0] _1 = 8'b1111_1001;
    localparam logic [7:0] _2 = 8'b1010_0100;
    localparam logic [7:0] _3 = 8'b1011_0000;
    localparam logic [7:0] _4 = 8'b1001_1001;
    localparam logic [7:0] _5 = 8'b1001_0010;
    localparam logic [7:0] _6 = 8'b1000_0010;
    localparam logic [7:0] _7 = 8'b1111_1000;
    localparam logic [7:0] _8 = 8'b1000_0000;
    localparam logic [7:0] _9 = 8'b1001_0000;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] COL_TEN = 2'b01;
    localparam logic [1:0] COL_ONE = 2'b10;
    localparam logic [1:0] COL_OFF = 2'b11;

    typedef enum logic [1:0] {
        SHOW_TEN = 2'd0,
        GAP_T    = 2'd1,
        SHOW_ONE = 2'd2,
        GAP_O    = 2'd3
    } scan_state_t;

    // Decimal digit to active-low segment pattern; anything else shows blank.
    function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return _0;
            4'd1:    return _1;
            4'd2:    return _2;
            4'd3:    return _3;
            4'd4:    return _4;
            4'd5:    return _5;
            4'd6:    return _6;
            4'd7:    return _7;
            4'd8:    return _8;
            4'd9:    return _9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/smg_slot_timer.sv
// rtl/smg_slot_timer.sv - 16-bit slot counter with terminal-count detect
module smg_slot_timer (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] load,
    input  logic        restart,
    output logic        done
);

    logic [15:0] count;

    always_ff @(posedge CLK) begin
        if (RST || restart) begin
            count <= 16'd0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign done = (count == load - 16'd1);

endmodule

// File: rtl/smg_scan_module.sv
// rtl/smg_scan_module.sv - two-digit multiplexed seven-segment scanner with dead time
module smg_scan_module
    import smg_pkg::*;
#(
    parameter int T_SCAN = 50000,
    parameter int T_GAP  = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic       Blank_Zero,
    input  logic [7:0] Ten_SMG_Data,
    input  logic [7:0] One_SMG_Data,
    output logic [7:0] Row_Scan_Sig,
    output logic [1:0] Column_Scan_Sig,
    output logic       Frame_Done
);

    localparam logic [15:0] SCAN_LEN = 16'(T_SCAN);
    localparam logic [15:0] GAP_LEN  = 16'(T_GAP);

    scan_state_t state_q, state_d;
    logic [7:0]  ten_q, ten_d;
    logic [7:0]  one_q, one_d;
    logic [7:0]  row_d;
    logic [1:0]  col_d;
    logic        frame_d;
    logic        first_q, first_d;
    logic        restart;
    logic        slot_done;
    logic [15:0] slot_len;

    assign slot_len = (state_q == SHOW_TEN || state_q == SHOW_ONE) ? SCAN_LEN : GAP_LEN;

    smg_slot_timer u_slot_timer (
        .CLK     (CLK),
        .RST     (RST),
        .load    (slot_len),
        .restart (restart),
        .done    (slot_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= GAP_O;
            ten_q           <= SEG_BLANK;
            one_q           <= SEG_BLANK;
            Row_Scan_Sig    <= SEG_BLANK;
            Column_Scan_Sig <= COL_OFF;
            Frame_Done      <= 1'b0;
            first_q         <= 1'b1;
        end else begin
            state_q         <= state_d;
            ten_q           <= ten_d;
            one_q           <= one_d;
            Row_Scan_Sig    <= row_d;
            Column_Scan_Sig <= col_d;
            Frame_Done      <= frame_d;
            first_q         <= first_d;
        end
    end

    // Outputs change only on slot entry, so inputs are latched once per slot.
    always_comb begin
        state_d = state_q;
        ten_d   = ten_q;
        one_d   = one_q;
        row_d   = Row_Scan_Sig;
        col_d   = Column_Scan_Sig;
        frame_d = 1'b0;
        first_d = first_q;
        restart = 1'b0;
        if (!Enable) begin
            state_d = GAP_O;
            restart = 1'b1;
            row_d   = SEG_BLANK;
            col_d   = COL_OFF;
            first_d = 1'b1;
        end else if (slot_done) begin
            restart = 1'b1;
            case (state_q)
                SHOW_TEN: begin
                    state_d = GAP_T;
                    row_d   = SEG_BLANK;
                    col_d   = COL_OFF;
                end
                GAP_T: begin
                    state_d = SHOW_ONE;
                    one_d   = One_SMG_Data;
                    row_d   = One_SMG_Data;
                    col_d   = COL_ONE;
                end
                SHOW_ONE: begin
                    state_d = GAP_O;
                    row_d   = SEG_BLANK;
                    col_d   = COL_OFF;
                end
                default: begin
                    state_d = SHOW_TEN;
                    ten_d   = Ten_SMG_Data;
                    frame_d = !first_q;
                    first_d = 1'b0;
                    if (Blank_Zero && Ten_SMG_Data == _0) begin
                        row_d = SEG_BLANK;
                        col_d = COL_OFF;
                    end else begin
                        row_d = Ten_SMG_Data;
                        col_d = COL_TEN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smg_scan_module.sv
// tb/tb_smg_scan_module.sv - scoreboard bench for smg_scan_module
module tb_smg_scan_module;
    import smg_pkg::*;

    typedef struct {
        logic [7:0] row;
        logic [1:0] col;
        logic       fd;
        int         idx;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Enable;
    logic       Blank_Zero;
    logic [7:0] Ten_SMG_Data;
    logic [7:0] One_SMG_Data;
    logic [7:0] row_a, row_b;
    logic [1:0] col_a, col_b;
    logic       fd_a, fd_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   idx_a = 0;
    int   idx_b = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic stim_done = 1'b0;

    always #5 CLK = ~CLK;

    smg_scan_module #(.T_SCAN(4), .T_GAP(2)) dut_a (
        .CLK             (CLK),
        .RST             (RST),
        .Enable          (Enable),
        .Blank_Zero      (Blank_Zero),
        .Ten_SMG_Data    (Ten_SMG_Data),
        .One_SMG_Data    (One_SMG_Data),
        .Row_Scan_Sig    (row_a),
        .Column_Scan_Sig (col_a),
        .Frame_Done      (fd_a)
    );

    smg_scan_module #(.T_SCAN(1), .T_GAP(1)) dut_b (
        .CLK             (CLK),
        .RST             (RST),
        .Enable          (Enable),
        .Blank_Zero      (Blank_Zero),
        .Ten_SMG_Data    (Ten_SMG_Data),
        .One_SMG_Data    (One_SMG_Data),
        .Row_Scan_Sig    (row_b),
        .Column_Scan_Sig (col_b),
        .Frame_Done      (fd_b)
    );

    task automatic step_a(input logic [7:0] r, input logic [1:0] c, input logic f);
        @(posedge CLK);
        #1;
        q_a.push_back('{row: r, col: c, fd: f, idx: idx_a});
        idx_a++;
    endtask

    task automatic step_b(input logic [7:0] r, input logic [1:0] c, input logic f);
        @(posedge CLK);
        #1;
        q_b.push_back('{row: r, col: c, fd: f, idx: idx_b});
        idx_b++;
    endtask

    // One full 12-cycle frame of dut_a starting at SHOW_TEN entry.
    task automatic frame_a(input logic [7:0] tr, input logic [1:0] tc,
                           input logic [7:0] orow, input logic fd);
        step_a(tr, tc, fd);
        repeat (3) step_a(tr, tc, 1'b0);
        repeat (2) step_a(SEG_BLANK, COL_OFF, 1'b0);
        repeat (4) step_a(orow, COL_ONE, 1'b0);
        repeat (2) step_a(SEG_BLANK, COL_OFF, 1'b0);
    endtask

    task automatic frame_b(input logic fd);
        step_b(_8, COL_TEN, fd);
        step_b(SEG_BLANK, COL_OFF, 1'b0);
        step_b(_9, COL_ONE, 1'b0);
        step_b(SEG_BLANK, COL_OFF, 1'b0);
    endtask

    initial begin
        RST          = 1'b1;
        Enable       = 1'b1;
        Blank_Zero   = 1'b0;
        Ten_SMG_Data = _1;
        One_SMG_Data = _2;

        repeat (3) step_a(SEG_BLANK, COL_OFF, 1'b0);
        RST = 1'b0;
        step_a(SEG_BLANK, COL_OFF, 1'b0);
        frame_a(_1, COL_TEN, _2, 1'b0);

        // Tens input changes mid-slot; must not tear.
        step_a(_1, COL_TEN, 1'b1);
        step_a(_1, COL_TEN, 1'b0);
        Ten_SMG_Data = _7;
        repeat (2) step_a(_1, COL_TEN, 1'b0);
        repeat (2) step_a(SEG_BLANK, COL_OFF, 1'b0);
        repeat (4) step_a(_2, COL_ONE, 1'b0);
        repeat (2) step_a(SEG_BLANK, COL_OFF, 1'b0);
        frame_a(_7, COL_TEN, _2, 1'b1);

        Ten_SMG_Data = _0;
        One_SMG_Data = _5;
        Blank_Zero   = 1'b1;
        frame_a(SEG_BLANK, COL_OFF, _5, 1'b1);
        Blank_Zero   = 1'b0;
        frame_a(_0, COL_TEN, _5, 1'b1);

        // Enable drop for one cycle in the middle of SHOW_ONE.
        Ten_SMG_Data = _3;
        One_SMG_Data = _4;
        step_a(_3, COL_TEN, 1'b1);
        repeat (3) step_a(_3, COL_TEN, 1'b0);
        repeat (2) step_a(SEG_BLANK, COL_OFF, 1'b0);
        repeat (2) step_a(_4, COL_ONE, 1'b0);
        Enable = 1'b0;
        step_a(SEG_BLANK, COL_OFF, 1'b0);
        Enable = 1'b1;
        step_a(SEG_BLANK, COL_OFF, 1'b0);
        frame_a(_3, COL_TEN, _4, 1'b0);

        repeat (5) frame_a(_3, COL_TEN, _4, 1'b1);

        // Reset in the middle of SHOW_TEN.
        step_a(_3, COL_TEN, 1'b1);
        step_a(_3, COL_TEN, 1'b0);
        RST = 1'b1;
        step_a(SEG_BLANK, COL_OFF, 1'b0);
        RST = 1'b0;
        step_a(SEG_BLANK, COL_OFF, 1'b0);
        frame_a(_3, COL_TEN, _4, 1'b0);

        // Minimum timing on dut_b.
        Ten_SMG_Data = _8;
        One_SMG_Data = _9;
        RST = 1'b1;
        repeat (2) step_b(SEG_BLANK, COL_OFF, 1'b0);
        RST = 1'b0;
        frame_b(1'b0);
        frame_b(1'b1);
        frame_b(1'b1);
        step_b(_8, COL_TEN, 1'b1);
        RST = 1'b1;
        step_b(SEG_BLANK, COL_OFF, 1'b0);
        RST = 1'b0;
        frame_b(1'b0);

        stim_done = 1'b1;
    end

    always @(negedge CLK) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            n_checks++;
            if ({row_a, col_a, fd_a} !== {e.row, e.col, e.fd}) begin
                n_fail++;
                $display("FAIL a_cycle[%0d] got row=%b col=%b fd=%b, want row=%b col=%b fd=%b",
                         e.idx, row_a, col_a, fd_a, e.row, e.col, e.fd);
            end
            n_checks++;
            if (col_a == 2'b00) begin
                n_fail++;
                $display("FAIL a_col_both_low[%0d] got col=%b, want not 00", e.idx, col_a);
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            n_checks++;
            if ({row_b, col_b, fd_b} !== {e.row, e.col, e.fd}) begin
                n_fail++;
                $display("FAIL b_cycle[%0d] got row=%b col=%b fd=%b, want row=%b col=%b fd=%b",
                         e.idx, row_b, col_b, fd_b, e.row, e.col, e.fd);
            end
            n_checks++;
            if (col_b == 2'b00) begin
                n_fail++;
                $display("FAIL b_col_both_low[%0d] got col=%b, want not 00", e.idx, col_b);
            end
        end
        if (stim_done) begin
            n_checks++;
            if (q_a.size() + q_b.size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain got %0d pending, want 0", q_a.size() + q_b.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got no end of stimulus, want completion before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/smg_scan_module.md
SMG_SCAN_MODULE -- requirements
Module: smg_scan_module

Interface
REQ-001 SHALL have parameter T_SCAN, default 50000, meaning clock cycles each digit is lit (1 ms at 50 MHz); legal range 1..65535.
REQ-002 SHALL have parameter T_GAP, default 500, meaning dead-time cycles with all digits off between digit slots; legal range 1..65535.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Enable  input  1  scanning runs when 1; display forced blank when 0.
REQ-006 SHALL have port Blank_Zero  input  1  when 1, tens digit stays unlit if its pattern equals the "0" pattern 8'b1100_0000.
REQ-007 SHALL have port Ten_SMG_Data  input  8  active-low segment pattern for the tens digit, from the encoder stage.
REQ-008 SHALL have port One_SMG_Data  input  8  active-low segment pattern for the ones digit, from the encoder stage.
REQ-009 SHALL have port Row_Scan_Sig  output  8  shared active-low segment bus to the panel.
REQ-010 SHALL have port Column_Scan_Sig  output  2  active-low digit select; bit1 = tens, bit0 = ones.
REQ-011 SHALL have port Frame_Done  output  1  one-cycle pulse per complete two-digit frame.

Function
REQ-012 SHALL cycle through four states, in order: SHOW_TEN (T_SCAN cycles), GAP_T (T_GAP cycles), SHOW_ONE (T_SCAN cycles), GAP_O (T_GAP cycles), then back to SHOW_TEN.
REQ-013 SHALL use a 16-bit slot counter that runs 0..N-1 within each state, where N is the state's duration, and clears to 0 on every state change.
REQ-014 SHALL register all outputs and align them with the state; no combinational path from inputs to outputs.
REQ-015 SHALL, in SHOW_TEN, drive Column_Scan_Sig=2'b01 and Row_Scan_Sig equal to the Ten_SMG_Data value sampled on the edge that enters SHOW_TEN, held constant for the whole slot.
REQ-016 SHALL, in SHOW_ONE, drive Column_Scan_Sig=2'b10 and Row_Scan_Sig equal to the One_SMG_Data value sampled on the edge that enters SHOW_ONE, held constant for the whole slot.
REQ-017 SHALL, in GAP_T and GAP_O, drive Column_Scan_Sig=2'b11 and Row_Scan_Sig=8'hFF.
REQ-018 SHALL treat input changes during a slot as invisible until the next entry into the matching SHOW state (no mid-slot tearing).
REQ-019 SHALL, when Blank_Zero=1 and the sampled tens pattern is 8'b1100_0000, keep Column_Scan_Sig=2'b11 and Row_Scan_Sig=8'hFF for the SHOW_TEN slot while still spending T_SCAN cycles there.
REQ-020 SHALL assert Frame_Done for exactly the first cycle of each SHOW_TEN slot, excluding the first SHOW_TEN after reset or after re-enable.
REQ-021 SHALL, on any cycle with Enable=0, go to GAP_O with counter 0, blank the outputs as in REQ-017, and hold Frame_Done=0.
REQ-022 SHALL, when Enable returns to 1, run a full T_GAP in GAP_O and then enter SHOW_TEN.
REQ-023 SHALL never assert both bits of Column_Scan_Sig low in the same cycle.
REQ-024 SHALL display non-decimal patterns, including 8'hFF from a reset encoder, verbatim without checking them.

Reset
REQ-025 SHALL, on RST=1 at a rising edge, set state=GAP_O, counter=0, Row_Scan_Sig=8'hFF, Column_Scan_Sig=2'b11, Frame_Done=0, and both sampled pattern registers=8'hFF.
REQ-026 SHALL give RST priority over Enable.
REQ-027 SHALL abort the current slot on reset asserted mid-slot, and SHALL begin after release with a full T_GAP gap.

Structure
REQ-028 SHALL place the segment constants _0.._9, the blank pattern 8'hFF, the state encoding and the column codes (01/10/11) in shared package smg_pkg, also used by smg_encoder_module.
REQ-029 SHALL implement the slot counter and terminal-count detection as sub-module smg_slot_timer, with inputs load value and restart and output done; the FSM and output registers stay in smg_scan_module.

Verification (T_SCAN=4, T_GAP=2 unless noted)
REQ-030 SHALL check reset: hold RST 3 cycles, release, Enable=1, Ten=_1, One=_2 -> outputs FF/11 for 2 cycles, then Row=8'b1111_1001 with Col=01 for 4 cycles, FF/11 for 2, Row=8'b1010_0100 with Col=10 for 4; frame period 12 cycles.
REQ-031 SHALL check mid-slot change: change Ten from _1 to _7 at cycle 2 of SHOW_TEN -> Row stays 8'b1111_1001 for the rest of the slot; the next SHOW_TEN shows 8'b1111_1000.
REQ-032 SHALL check leading-zero blanking: Ten=_0, One=_5, Blank_Zero=1 -> tens slot FF/11; ones slot Row=8'b1001_0010, Col=10. With Blank_Zero=0, the tens slot shows 8'b1100_0000 with Col=01.
REQ-033 SHALL check Enable drop: Enable=0 for 1 cycle mid SHOW_ONE -> next cycle FF/11; after re-enable 2 gap cycles, then SHOW_TEN, with no Frame_Done on that first slot.
REQ-034 SHALL check Frame_Done cadence over 5 frames: single-cycle pulses exactly 12 cycles apart, and Column_Scan_Sig never 2'b00.
REQ-035 SHALL check boundaries: T_SCAN=1, T_GAP=1 -> frame period 4 cycles, correct order; RST asserted mid SHOW_TEN -> next cycle matches REQ-025 values.
